exa_traffic_checker_vc: RTL and testbench
=========================================

EXA_TRAFFIC_CHECKER_VC -- requirements
Module: exa_traffic_checker_vc

Interface
REQ-001 Parameter PRIO_NUM, default 2, number of priority levels.
REQ-002 Parameter VC_NUM, default 2, virtual channels per priority; CH = VC_NUM*PRIO_NUM channels.
REQ-003 Parameter MAX_PAYLOAD, default 16, maximum payload flits per packet (1..255).
REQ-004 Parameter LFSR_SEED, default 16'hACE1, non-zero reset value of the backpressure LFSR.
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 resetn  input  1  reset, asynchronous, active-low.
REQ-007 i_backpressure  input  5  ready threshold; 0 means never stall, 31 means stall on all but 1/32 of cycles.
REQ-008 i_vc  input  $clog2(CH)  channel of the arriving packet, sampled only at header handshake.
REQ-009 exa  exanet.slave  --  ExaNet receive side: header/payload/footer valid, 128-bit data in; the three readies out.
REQ-010 o_pkt_cnt  output  CH*32  per-channel count of completed packets, channel c at bits [32c+31:32c].
REQ-011 o_err_cnt  output  32  total detected errors, saturating.
REQ-012 o_err  output  1  sticky error flag.
REQ-013 o_busy  output  1  high while a packet is open (after header, before footer).

Function
REQ-014 Expected flit word for channel c, sequence s, flit index f SHALL be {c[7:0], s[31:0], f[7:0], 80'h0}; header f=0, payload f=1..n, footer f=n+1.
REQ-015 States: IDLE (expect header), BODY (payload or footer); reset state IDLE.
REQ-016 IDLE + header handshake: latch ch=i_vc, flit index=1, compare data with f=0, go BODY.
REQ-017 BODY + payload handshake: compare with current index, index+1.
REQ-018 BODY + footer handshake: compare with current index, increment o_pkt_cnt[ch] and seq[ch] (32-bit wrap 0xFFFFFFFF->0), go IDLE.
REQ-019 Each data mismatch SHALL increment o_err_cnt by one and set o_err the cycle after the handshake.
REQ-020 Protocol errors, each counted once: payload/footer handshake in IDLE (ignored, stay IDLE); header in BODY (abandon open packet, restart with new header, no pkt_cnt increment); footer with zero payload flits; payload beyond MAX_PAYLOAD (flit discarded, stay BODY).
REQ-021 Several valids in one handshake cycle: process header > payload > footer, count one protocol error.
REQ-022 Data mismatch and protocol error in the same flit SHALL count as one error.
REQ-023 o_err_cnt SHALL saturate at 32'hFFFFFFFF; o_pkt_cnt entries wrap.
REQ-024 i_vc >= CH at header: protocol error, packet dropped, stay IDLE.
REQ-025 Readies SHALL be combinational from registered LFSR only (no valid->ready path); all three readies equal.

Reset
REQ-026 While resetn low: readies 0, o_pkt_cnt all 0, o_err_cnt 0, o_err 0, o_busy 0, seq all 0, LFSR = LFSR_SEED, state IDLE.
REQ-027 Reset mid-packet SHALL discard the open packet without counting it or an error.

Configuration
REQ-028 Macro EXA_TRAFFIC_CHECKER_BACKPRESSURE_EN defined: 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle out of reset; ready = lfsr[4:0] >= i_backpressure.
REQ-029 Macro undefined: LFSR absent, readies = 1 whenever resetn high, i_backpressure ignored.

Verification
REQ-030 i_backpressure=0, channel 3, 4 payloads, correct pattern -> o_pkt_cnt[3]=1, o_err_cnt=0, next header expected with s=1.
REQ-031 Payload flit 2 of channel 0 with bit 0 flipped -> o_err_cnt=1, o_err=1, o_pkt_cnt[0]=1 after footer.
REQ-032 Footer straight after header on channel 1 -> o_err_cnt=1, o_pkt_cnt[1]=0; 17 payloads with MAX_PAYLOAD=16 -> o_err_cnt=1.
REQ-033 i_backpressure=31, 200 packets round-robin over 4 channels, macro defined -> each o_pkt_cnt=50, o_err_cnt=0, readies visibly stall.
REQ-034 resetn pulsed low after 3 payloads -> all counters 0, o_busy 0; fresh packet on same channel with s=0 passes.
REQ-035 o_err_cnt preloaded to 32'hFFFFFFFE via forced errors, 3 more errors -> stays 32'hFFFFFFFF.

Source files
------------

// File: rtl/exa_traffic_checker_vc_if.sv
// -----------------------------------------------------------------------------
// exanet -- ExaNet receive-side handshake bundle.
//
// The three flit classes (header, payload, footer) each have their own valid
// and ready and share one 128-bit data bus.
//
//   hdr_valid / pld_valid / ftr_valid  master -> slave  flit class valid
//   data[127:0]                        master -> slave  flit word
//   hdr_ready / pld_ready / ftr_ready  slave -> master  flit class ready
//
// A flit transfers on a rising clock edge where its valid and ready are
// both high.
// -----------------------------------------------------------------------------
interface exanet;
  logic         hdr_valid;
  logic         pld_valid;
  logic         ftr_valid;
  logic [127:0] data;
  logic         hdr_ready;
  logic         pld_ready;
  logic         ftr_ready;

  modport master (
    output hdr_valid, pld_valid, ftr_valid, data,
    input  hdr_ready, pld_ready, ftr_ready
  );

  modport slave (
    input  hdr_valid, pld_valid, ftr_valid, data,
    output hdr_ready, pld_ready, ftr_ready
  );
endinterface

// File: rtl/exa_traffic_checker_vc.sv
// -----------------------------------------------------------------------------
// exa_traffic_checker_vc -- ExaNet receive-side traffic checker.
//
// Every received packet (header, 1..MAX_PAYLOAD payload flits, footer) is
// compared against the generated pattern {ch[7:0], seq[31:0], flit[7:0], 80'h0}.
// The checker counts completed packets per channel and counts data and
// protocol errors in one saturating counter with a sticky error flag.
//
// Ports
//   clk             clock, all state on the rising edge
//   resetn          asynchronous active-low reset
//   i_backpressure  ready threshold (0 = never stall, 31 = ready 1/32 cycles)
//   i_vc            channel of the arriving packet, used at header handshake
//   exa             exanet.slave receive interface
//   o_pkt_cnt       per-channel completed packet counts, channel c at [32c+:32]
//   o_err_cnt       saturating count of detected errors
//   o_err           sticky error flag
//   o_busy          a packet is open (header accepted, footer not yet)
//
// Configuration
//   EXA_TRAFFIC_CHECKER_BACKPRESSURE_EN  defined: readies are throttled by a
//   16-bit Fibonacci LFSR (taps 16,14,13,11). Undefined: readies are high
//   whenever resetn is high and i_backpressure is ignored.
// -----------------------------------------------------------------------------
module exa_traffic_checker_vc #(
  parameter  int          PRIO_NUM    = 2,
  parameter  int          VC_NUM      = 2,
  parameter  int          MAX_PAYLOAD = 16,
  parameter  logic [15:0] LFSR_SEED   = 16'hACE1,
  localparam int          CH          = VC_NUM * PRIO_NUM,
  localparam int          VCW         = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [4:0]      i_backpressure,
  input  logic [VCW-1:0]  i_vc,
  exanet.slave            exa,
  output logic [CH*32-1:0] o_pkt_cnt,
  output logic [31:0]     o_err_cnt,
  output logic            o_err,
  output logic            o_busy
);

  typedef enum logic {
    ST_IDLE,
    ST_BODY
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [VCW-1:0] r_ch;
  logic [VCW-1:0] w_ch_nxt;
  // Footer of a full packet sits at index MAX_PAYLOAD+1, which can be 256.
  logic [8:0]    r_idx;
  logic [8:0]    w_idx_nxt;
  logic [31:0]   r_seq [CH];
  logic [31:0]   r_pkt [CH];
  logic [31:0]   r_err_cnt;
  logic [31:0]   w_err_cnt_nxt;
  logic          r_err;

  logic          w_ready;
  logic          w_hs_hdr;
  logic          w_hs_pld;
  logic          w_hs_ftr;
  logic          w_multi;
  logic          w_vc_ok;
  logic [31:0]   w_hdr_seq;
  logic [127:0]  w_hdr_word;
  logic [127:0]  w_body_word;
  logic          w_cmp_hdr;
  logic          w_cmp_body;
  logic          w_proto_err;
  logic          w_mismatch;
  logic          w_err_evt;
  logic          w_pkt_done;

  // ---------------------------------------------------------------------------
  // Ready generation: depends only on registered state and the threshold, so
  // there is no combinational path from any valid to any ready.
  // ---------------------------------------------------------------------------
`ifdef EXA_TRAFFIC_CHECKER_BACKPRESSURE_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
  end

  assign w_ready = resetn & (r_lfsr[4:0] >= i_backpressure);
`else
  logic w_unused_bp;
  assign w_unused_bp = ^i_backpressure;
  assign w_ready     = resetn;
`endif

  assign exa.hdr_ready = w_ready;
  assign exa.pld_ready = w_ready;
  assign exa.ftr_ready = w_ready;

  // Priority header > payload > footer when several valids coincide.
  assign w_hs_hdr = w_ready & exa.hdr_valid;
  assign w_hs_pld = w_ready & exa.pld_valid & ~exa.hdr_valid;
  assign w_hs_ftr = w_ready & exa.ftr_valid & ~exa.hdr_valid & ~exa.pld_valid;
  assign w_multi  = w_ready & ((exa.hdr_valid & exa.pld_valid) |
                               (exa.hdr_valid & exa.ftr_valid) |
                               (exa.pld_valid & exa.ftr_valid));

  assign w_vc_ok = (32'(i_vc) < CH);

  always_comb begin
    w_hdr_seq = '0;
    for (int c = 0; c < CH; c++) begin
      if (i_vc == VCW'(c)) w_hdr_seq = r_seq[c];
    end
  end

  assign w_hdr_word  = {8'(i_vc), w_hdr_seq, 8'h00, 80'h0};
  assign w_body_word = {8'(r_ch), r_seq[r_ch], r_idx[7:0], 80'h0};

  // ---------------------------------------------------------------------------
  // Next-state and event decode.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    w_state_nxt = r_state;
    w_ch_nxt    = r_ch;
    w_idx_nxt   = r_idx;
    w_cmp_hdr   = 1'b0;
    w_cmp_body  = 1'b0;
    w_proto_err = w_multi;
    w_pkt_done  = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (w_hs_hdr) begin
          if (w_vc_ok) begin
            w_ch_nxt    = i_vc;
            w_idx_nxt   = 9'd1;
            w_cmp_hdr   = 1'b1;
            w_state_nxt = ST_BODY;
          end else begin
            w_proto_err = 1'b1;
          end
        end else if (w_hs_pld || w_hs_ftr) begin
          w_proto_err = 1'b1;
        end
      end

      ST_BODY: begin
        if (w_hs_hdr) begin
          // Open packet is abandoned; the new header starts afresh.
          w_proto_err = 1'b1;
          if (w_vc_ok) begin
            w_ch_nxt  = i_vc;
            w_idx_nxt = 9'd1;
            w_cmp_hdr = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else if (w_hs_pld) begin
          if (r_idx > 9'(MAX_PAYLOAD)) begin
            w_proto_err = 1'b1;
          end else begin
            w_cmp_body = 1'b1;
            w_idx_nxt  = r_idx + 9'd1;
          end
        end else if (w_hs_ftr) begin
          w_cmp_body  = 1'b1;
          w_state_nxt = ST_IDLE;
          if (r_idx == 9'd1) w_proto_err = 1'b1;
          else               w_pkt_done  = 1'b1;
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_mismatch = (w_cmp_hdr  && (exa.data != w_hdr_word)) ||
                      (w_cmp_body && (exa.data != w_body_word));
  // A flit with both a data and a protocol error counts once.
  assign w_err_evt     = w_proto_err | w_mismatch;
  assign w_err_cnt_nxt = (w_err_evt && (r_err_cnt != 32'hFFFF_FFFF)) ?
                         r_err_cnt + 32'd1 : r_err_cnt;

  // ---------------------------------------------------------------------------
  // State registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_ch      <= '0;
      r_idx     <= '0;
      r_err_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ch      <= w_ch_nxt;
      r_idx     <= w_idx_nxt;
      r_err_cnt <= w_err_cnt_nxt;
      r_err     <= r_err | w_err_evt;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: the per-channel arrays are small register files whose contents
    // are architectural (sequence restarts at 0), so they are reset too.
    if (!resetn) begin
      for (int c = 0; c < CH; c++) begin
        r_seq[c] <= '0;
        r_pkt[c] <= '0;
      end
    end else begin
      for (int c = 0; c < CH; c++) begin
        if (w_pkt_done && (r_ch == VCW'(c))) begin
          r_seq[c] <= r_seq[c] + 32'd1;
          r_pkt[c] <= r_pkt[c] + 32'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs.
  // ---------------------------------------------------------------------------
  always_comb begin
    o_pkt_cnt = '0;
    for (int c = 0; c < CH; c++) begin
      o_pkt_cnt[32*c +: 32] = r_pkt[c];
    end
  end

  assign o_err_cnt = r_err_cnt;
  assign o_err     = r_err;
  assign o_busy    = (r_state == ST_BODY);

endmodule

// File: tb/tb_exa_traffic_checker_vc.sv
// -----------------------------------------------------------------------------
// tb_exa_traffic_checker_vc -- self-checking bench for exa_traffic_checker_vc.
//
// Directed and randomized packets are driven through the exanet interface.
// A packet-level model (per-channel packet and sequence counts, a saturating
// error count) predicts every observed output.
// -----------------------------------------------------------------------------
module tb_exa_traffic_checker_vc;

  localparam int CH          = 4;
  localparam int MAX_PAYLOAD = 16;
  localparam int TMO         = 2000;

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic [4:0]     bp = '0;
  logic [1:0]     vc = '0;
  logic [CH*32-1:0] o_pkt_cnt;
  logic [31:0]    o_err_cnt;
  logic           o_err;
  logic           o_busy;

  exanet exa_if ();

  exa_traffic_checker_vc dut (
    .clk           (clk),
    .resetn        (resetn),
    .i_backpressure(bp),
    .i_vc          (vc),
    .exa           (exa_if),
    .o_pkt_cnt     (o_pkt_cnt),
    .o_err_cnt     (o_err_cnt),
    .o_err         (o_err),
    .o_busy        (o_busy)
  );

  always #5 clk = ~clk;

  int          n_total = 0;
  int          n_pass  = 0;
  int          stall_cnt = 0;
  int unsigned m_pkt [CH];
  logic [31:0] m_seq [CH];
  logic [31:0] m_err;
  logic        m_err_flag;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [127:0] word(input int c, input logic [31:0] s, input int f);
    logic [7:0] cb;
    logic [7:0] fb;
    cb = 8'(c);
    fb = 8'(f);
    return {cb, s, fb, 80'h0};
  endfunction

  function automatic logic [CH*32-1:0] model_pkt();
    logic [CH*32-1:0] v;
    v = '0;
    for (int c = 0; c < CH; c++) v[32*c +: 32] = m_pkt[c];
    return v;
  endfunction

  task automatic model_error();
    if (m_err != 32'hFFFF_FFFF) m_err = m_err + 32'd1;
    m_err_flag = 1'b1;
  endtask

  task automatic check_all(input string tag, input logic busy_exp);
    check({tag, "_pkt"},  o_pkt_cnt, model_pkt());
    check({tag, "_err"},  o_err_cnt, m_err);
    check({tag, "_flag"}, o_err,     m_err_flag);
    check({tag, "_busy"}, o_busy,    busy_exp);
  endtask

  // Drives one handshake cycle; returns #1 after the accepting edge.
  task automatic send(input logic h, input logic p, input logic f,
                      input logic [127:0] d, input logic [1:0] c);
    int waited;
    waited = 0;
    @(negedge clk);
    exa_if.hdr_valid = h;
    exa_if.pld_valid = p;
    exa_if.ftr_valid = f;
    exa_if.data      = d;
    vc               = c;
    while (exa_if.hdr_ready !== 1'b1 && waited < TMO) begin
      stall_cnt++;
      @(negedge clk);
      waited++;
    end
    if (waited >= TMO) begin
      n_total++;
      $error("FAIL ready_timeout observed=no_ready expected=ready_within_%0d", TMO);
    end else begin
      @(posedge clk);
      #1;
    end
    exa_if.hdr_valid = 1'b0;
    exa_if.pld_valid = 1'b0;
    exa_if.ftr_valid = 1'b0;
  endtask

  // Whole well-formed packet; bad_flit >= 0 flips one bit of that flit.
  task automatic send_packet(input int c, input int npld, input int bad_flit, input int bit_pos);
    logic [127:0] d;
    for (int f = 0; f <= npld + 1; f++) begin
      d = word(c, m_seq[c], f);
      if (f == bad_flit) d[bit_pos] = ~d[bit_pos];
      send(f == 0, (f > 0) && (f <= npld), f == npld + 1, d, 2'(c));
    end
    if (bad_flit >= 0) model_error();
    m_pkt[c]++;
    m_seq[c] = m_seq[c] + 32'd1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check("rst_ready", {exa_if.hdr_ready, exa_if.pld_ready, exa_if.ftr_ready}, 3'b000);
    check("rst_pkt",   o_pkt_cnt, '0);
    check("rst_err",   o_err_cnt, 32'd0);
    check("rst_state", {o_err, o_busy}, 2'b00);
    for (int c = 0; c < CH; c++) begin
      m_pkt[c] = 0;
      m_seq[c] = '0;
    end
    m_err      = '0;
    m_err_flag = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    int c;
    int npld;
    int bad;
    exa_if.hdr_valid = 1'b0;
    exa_if.pld_valid = 1'b0;
    exa_if.ftr_valid = 1'b0;
    exa_if.data      = '0;

    // Reset state, then a clean packet on channel 3 and its successor (s=1).
    do_reset();
    bp = 5'd0;
    #1;
    check("ready_equal", {exa_if.pld_ready, exa_if.ftr_ready}, {exa_if.hdr_ready, exa_if.hdr_ready});
    send_packet(3, 4, -1, 0);
    check_all("ch3_first", 1'b0);
    send_packet(3, 2, -1, 0);
    check_all("ch3_seq1", 1'b0);

    // Payload flit 2 of channel 0 with bit 0 flipped.
    send(1'b1, 1'b0, 1'b0, word(0, m_seq[0], 0), 2'd0);
    send(1'b0, 1'b1, 1'b0, word(0, m_seq[0], 1), 2'd0);
    send(1'b0, 1'b1, 1'b0, word(0, m_seq[0], 2) ^ 128'd1, 2'd0);
    model_error();
    check_all("bit0_flip_now", 1'b1);
    send(1'b0, 1'b0, 1'b1, word(0, m_seq[0], 3), 2'd0);
    m_pkt[0]++;
    m_seq[0] = m_seq[0] + 32'd1;
    check_all("bit0_flip_done", 1'b0);

    // Footer straight after header: error, no count, sequence unchanged.
    do_reset();
    send(1'b1, 1'b0, 1'b0, word(1, m_seq[1], 0), 2'd1);
    send(1'b0, 1'b0, 1'b1, word(1, m_seq[1], 1), 2'd1);
    model_error();
    check_all("empty_pkt", 1'b0);
    send_packet(1, 1, -1, 0);
    check_all("after_empty", 1'b0);

    // 17 payloads: the 17th is discarded, footer still expects index 17.
    do_reset();
    send(1'b1, 1'b0, 1'b0, word(2, m_seq[2], 0), 2'd2);
    for (int f = 1; f <= MAX_PAYLOAD + 1; f++) send(1'b0, 1'b1, 1'b0, word(2, m_seq[2], f), 2'd2);
    model_error();
    check_all("overlong_body", 1'b1);
    send(1'b0, 1'b0, 1'b1, word(2, m_seq[2], MAX_PAYLOAD + 1), 2'd2);
    m_pkt[2]++;
    m_seq[2] = m_seq[2] + 32'd1;
    check_all("overlong_done", 1'b0);

    // Payload in IDLE is ignored but counted.
    send(1'b0, 1'b1, 1'b0, 128'h1234, 2'd0);
    model_error();
    check_all("pld_in_idle", 1'b0);

    // Header inside an open packet abandons it.
    send(1'b1, 1'b0, 1'b0, word(0, m_seq[0], 0), 2'd0);
    send(1'b0, 1'b1, 1'b0, word(0, m_seq[0], 1), 2'd0);
    send(1'b1, 1'b0, 1'b0, word(1, m_seq[1], 0), 2'd1);
    model_error();
    check_all("hdr_in_body", 1'b1);
    send(1'b0, 1'b1, 1'b0, word(1, m_seq[1], 1), 2'd1);
    send(1'b0, 1'b0, 1'b1, word(1, m_seq[1], 2), 2'd1);
    m_pkt[1]++;
    m_seq[1] = m_seq[1] + 32'd1;
    check_all("restart_done", 1'b0);

    // Header and payload valid together: header wins, one error.
    send(1'b1, 1'b1, 1'b0, word(2, m_seq[2], 0), 2'd2);
    model_error();
    check_all("multi_valid", 1'b1);
    send(1'b0, 1'b1, 1'b0, word(2, m_seq[2], 1), 2'd2);
    send(1'b0, 1'b0, 1'b1, word(2, m_seq[2], 2), 2'd2);
    m_pkt[2]++;
    m_seq[2] = m_seq[2] + 32'd1;
    check_all("multi_done", 1'b0);

    // Randomized packets with occasional single-bit corruption.
    for (int i = 0; i < 30; i++) begin
      c    = int'($urandom_range(CH - 1, 0));
      npld = int'($urandom_range(MAX_PAYLOAD, 1));
      bad  = ($urandom_range(3, 0) == 0) ? int'($urandom_range(npld + 1, 0)) : -1;
      send_packet(c, npld, bad, int'($urandom_range(127, 0)));
      check_all("random_pkt", 1'b0);
    end

    // Heavy backpressure, 200 packets round-robin.
    do_reset();
    bp = 5'd31;
    stall_cnt = 0;
    for (int i = 0; i < 200; i++) send_packet(i % CH, int'($urandom_range(2, 1)), -1, 0);
    for (int k = 0; k < CH; k++) check("bp_pkt_cnt", o_pkt_cnt[32*k +: 32], 32'd50);
    check_all("bp_final", 1'b0);
`ifdef EXA_TRAFFIC_CHECKER_BACKPRESSURE_EN
    check("bp_stalled", stall_cnt > 0, 1'b1);
`else
    check("bp_no_stall", stall_cnt, 0);
`endif
    bp = 5'd0;

    // Reset in the middle of a packet.
    send(1'b1, 1'b0, 1'b0, word(1, m_seq[1], 0), 2'd1);
    for (int f = 1; f <= 3; f++) send(1'b0, 1'b1, 1'b0, word(1, m_seq[1], f), 2'd1);
    check("mid_busy", o_busy, 1'b1);
    do_reset();
    check_all("mid_after_rst", 1'b0);
    send_packet(1, 2, -1, 0);
    check_all("mid_fresh", 1'b0);

    // Error counter saturation.
    @(negedge clk);
    force dut.r_err_cnt = 32'hFFFF_FFFE;
    @(posedge clk);
    #1;
    release dut.r_err_cnt;
    m_err = 32'hFFFF_FFFE;
    check("sat_preload", o_err_cnt, m_err);
    for (int i = 0; i < 3; i++) begin
      send(1'b0, 1'b0, 1'b1, 128'h0, 2'd0);
      model_error();
      check("sat_err", o_err_cnt, m_err);
    end
    check("sat_final", o_err_cnt, 32'hFFFF_FFFF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
